// File: rtl/dvs_pkg.sv
// Shared definitions for the DVS event decoder: packet framing constants,
// field widths, decoder FSM state type and a saturating-increment helper.
package dvs_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned PKT_LEN   = 7;
  localparam int unsigned COORD_W   = 9;
  localparam int unsigned TS_W      = 16;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    STALL   = 2'd2
  } dvs_state_t;

  // Error counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == '1) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dvs_event_decoder.sv
// DVS event decoder: turns a UART byte stream of 7-byte event packets
// (sync 0xA5, x/y/polarity/timestamp payload, XOR checksum) into
// one-register-deep event outputs with valid/ready handshakes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_data/in_ready    byte input handshake (ready low only in STALL)
//   event_valid/event_ready      event output handshake
//   event_x, event_y             coordinates (0..SENSOR_RES-1)
//   event_polarity               1 = ON, 0 = OFF
//   event_ts                     16-bit timestamp
//   chk_err_count                saturating checksum failure count
//   range_drop_count             saturating out-of-range drop count
//   timeout_count                saturating inter-byte timeout count
module dvs_event_decoder
  import dvs_pkg::*;
#(
  parameter int unsigned SENSOR_RES     = 320,
  parameter int unsigned TIMEOUT_CYCLES = 12_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               event_valid,
  output logic [COORD_W-1:0] event_x,
  output logic [COORD_W-1:0] event_y,
  output logic               event_polarity,
  output logic [TS_W-1:0]    event_ts,
  input  logic               event_ready,
  output logic [7:0]         chk_err_count,
  output logic [7:0]         range_drop_count,
  output logic [7:0]         timeout_count
);

  localparam int unsigned TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]   LAST_IDX = 3'(PKT_LEN - 1);

  dvs_state_t        state;
  logic [2:0]        idx;
  logic [7:0]        xor_acc;
  logic [TO_W-1:0]   tcnt;
  logic [7:0]        b1, b2, b4, b5;
  logic [2:0]        b3_hi;     // only y[1:0] and polarity live in B3

  logic              accept;
  logic              out_free;
  logic              last_byte;
  logic              chk_ok;
  logic              in_range;
  logic              load_evt;
  logic [COORD_W-1:0] dec_x, dec_y;
  logic              dec_pol;
  logic [TS_W-1:0]   dec_ts;

  assign in_ready = (state != STALL);
  assign accept   = in_valid && in_ready;
  // Output register can take a new event if empty or draining this cycle.
  assign out_free = !event_valid || event_ready;

  always_comb begin
    dec_x     = {b1, b2[7]};
    dec_y     = {b2[6:0], b3_hi[2:1]};
    dec_pol   = b3_hi[0];
    dec_ts    = {b4, b5};
    last_byte = (state == COLLECT) && accept && (idx == LAST_IDX);
    chk_ok    = (in_data == xor_acc);
    in_range  = ({23'd0, dec_x} < SENSOR_RES) && ({23'd0, dec_y} < SENSOR_RES);
    // Fields are held in b1..b5 through STALL since no bytes are accepted there.
    load_evt  = out_free && ((last_byte && chk_ok && in_range) || (state == STALL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= HUNT;
      idx              <= '0;
      xor_acc          <= '0;
      tcnt             <= '0;
      b1               <= '0;
      b2               <= '0;
      b3_hi            <= '0;
      b4               <= '0;
      b5               <= '0;
      chk_err_count    <= '0;
      range_drop_count <= '0;
      timeout_count    <= '0;
    end else begin
      case (state)
        HUNT: begin
          tcnt <= '0;
          if (accept && in_data == SYNC_BYTE) begin
            idx     <= 3'd1;
            xor_acc <= '0;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            tcnt <= '0;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= HUNT;
              if (!chk_ok)
                chk_err_count <= sat_inc(chk_err_count);
              else if (!in_range)
                range_drop_count <= sat_inc(range_drop_count);
              else if (!out_free)
                state <= STALL;
            end else begin
              case (idx)
                3'd1:    b1    <= in_data;
                3'd2:    b2    <= in_data;
                3'd3:    b3_hi <= in_data[7:5];
                3'd4:    b4    <= in_data;
                3'd5:    b5    <= in_data;
                default: ;
              endcase
              xor_acc <= xor_acc ^ in_data;
              idx     <= idx + 3'd1;
            end
          end else if (tcnt == TO_MAX) begin
            tcnt          <= '0;
            idx           <= '0;
            state         <= HUNT;
            timeout_count <= sat_inc(timeout_count);
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        STALL: begin
          tcnt <= '0;
          if (out_free)
            state <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      event_valid    <= 1'b0;
      event_x        <= '0;
      event_y        <= '0;
      event_polarity <= 1'b0;
      event_ts       <= '0;
    end else if (load_evt) begin
      event_valid    <= 1'b1;
      event_x        <= dec_x;
      event_y        <= dec_y;
      event_polarity <= dec_pol;
      event_ts       <= dec_ts;
    end else if (event_valid && event_ready) begin
      event_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvs_event_decoder.sv
// Self-checking bench for dvs_event_decoder: table of packets plus
// hand-written stall, timeout, reset and saturation sequences. Expected
// events go to a queue when a packet is driven and are compared when the
// decoder hands them over.
module tb_dvs_event_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        event_valid;
  logic [8:0]  event_x;
  logic [8:0]  event_y;
  logic        event_polarity;
  logic [15:0] event_ts;
  logic        event_ready;
  logic [7:0]  chk_err_count;
  logic [7:0]  range_drop_count;
  logic [7:0]  timeout_count;

  dvs_event_decoder #(.SENSOR_RES(320), .TIMEOUT_CYCLES(12_000)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .event_valid      (event_valid),
    .event_x          (event_x),
    .event_y          (event_y),
    .event_polarity   (event_polarity),
    .event_ts         (event_ts),
    .event_ready      (event_ready),
    .chk_err_count    (chk_err_count),
    .range_drop_count (range_drop_count),
    .timeout_count    (timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic        pol;
    logic [15:0] ts;
  } evt_t;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic        pol;
    logic [15:0] ts;
    logic        corrupt;
    logic        garbage;
  } vec_t;

  evt_t        exp_q[$];
  evt_t        mon_e;
  vec_t        vt[10];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_chk = 0;
  int unsigned exp_rng = 0;
  int unsigned exp_to  = 0;
  logic        exp_evt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Consumer side: every handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual x=%0d y=%0d required none", event_x, event_y);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_x",   32'(event_x),        32'(mon_e.x));
        check("evt_y",   32'(event_y),        32'(mon_e.y));
        check("evt_pol", 32'(event_polarity), 32'(mon_e.pol));
        check("evt_ts",  32'(event_ts),       32'(mon_e.ts));
      end
    end
  end

  function automatic logic good_pkt(input logic [8:0] x, input logic [8:0] y, input logic corrupt);
    return !corrupt && (x < 9'd320) && (y < 9'd320);
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait actual=0 required=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [8:0] x, input logic [8:0] y, input logic pol,
                          input logic [15:0] ts, input logic corrupt);
    logic [7:0] p [7];
    evt_t       e;
    p[0] = 8'hA5;
    p[1] = x[8:1];
    p[2] = {x[0], y[8:2]};
    p[3] = {y[1:0], pol, 5'b0};
    p[4] = ts[15:8];
    p[5] = ts[7:0];
    p[6] = p[1] ^ p[2] ^ p[3] ^ p[4] ^ p[5];
    if (corrupt) p[6] = p[6] ^ 8'h01;
    if (good_pkt(x, y, corrupt)) begin
      e.x = x; e.y = y; e.pol = pol; e.ts = ts;
      exp_q.push_back(e);
    end else if (corrupt) begin
      exp_chk = (exp_chk < 255) ? exp_chk + 1 : 255;
    end else begin
      exp_rng = (exp_rng < 255) ? exp_rng + 1 : 255;
    end
    for (int i = 0; i < 7; i++) send_byte(p[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{9'd100, 9'd200, 1'b1, 16'h1234, 1'b0, 1'b0};
    vt[1] = '{9'd100, 9'd200, 1'b1, 16'h1234, 1'b1, 1'b0};
    vt[2] = '{9'd5,   9'd7,   1'b0, 16'hBEEF, 1'b0, 1'b0};
    vt[3] = '{9'd320, 9'd0,   1'b0, 16'h0000, 1'b0, 1'b1};
    vt[4] = '{9'd319, 9'd319, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vt[5] = '{9'd0,   9'd0,   1'b0, 16'h0000, 1'b0, 1'b0};
    vt[6] = '{9'd0,   9'd320, 1'b1, 16'h0001, 1'b0, 1'b0};
    vt[7] = '{9'd511, 9'd511, 1'b1, 16'h8000, 1'b0, 1'b0};
    vt[8] = '{9'd10,  9'd11,  1'b0, 16'hA5A5, 1'b0, 1'b1};
    vt[9] = '{9'd200, 9'd100, 1'b0, 16'h0F0F, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; event_ready = 1'b1;
    idle(3);
    check("rst_event_valid", 32'(event_valid),      32'd0);
    check("rst_in_ready",    32'(in_ready),         32'd1);
    check("rst_event_x",     32'(event_x),          32'd0);
    check("rst_event_ts",    32'(event_ts),         32'd0);
    check("rst_chk_cnt",     32'(chk_err_count),    32'd0);
    check("rst_rng_cnt",     32'(range_drop_count), 32'd0);
    check("rst_to_cnt",      32'(timeout_count),    32'd0);
    rst = 1'b0;
    idle(2);

    // Table of single packets, consumer always ready.
    for (int i = 0; i < 10; i++) begin
      if (vt[i].garbage) begin
        send_byte(8'h00);
        send_byte(8'hFF);
      end
      exp_evt = good_pkt(vt[i].x, vt[i].y, vt[i].corrupt);
      send_pkt(vt[i].x, vt[i].y, vt[i].pol, vt[i].ts, vt[i].corrupt);
      check("latency_event_valid", 32'(event_valid), 32'(exp_evt));
      idle(3);
      check("tbl_chk_cnt", 32'(chk_err_count),    exp_chk);
      check("tbl_rng_cnt", 32'(range_drop_count), exp_rng);
      check("tbl_queue",   32'(exp_q.size()),     32'd0);
    end

    // Back-pressure: second packet parks in STALL, third waits on in_ready.
    event_ready = 1'b0;
    send_pkt(9'd10, 9'd20, 1'b1, 16'h1111, 1'b0);
    send_pkt(9'd30, 9'd40, 1'b0, 16'h2222, 1'b0);
    check("stall_in_ready", 32'(in_ready),    32'd0);
    check("stall_valid",    32'(event_valid), 32'd1);
    idle(5);
    check("hold_x",   32'(event_x),        32'd10);
    check("hold_y",   32'(event_y),        32'd20);
    check("hold_pol", 32'(event_polarity), 32'd1);
    check("hold_ts",  32'(event_ts),       32'h1111);
    check("stall_in_ready_held", 32'(in_ready), 32'd0);
    fork
      send_pkt(9'd50, 9'd60, 1'b1, 16'h3333, 1'b0);
      begin
        idle(4);
        event_ready = 1'b1;
      end
    join
    idle(5);
    check("stall_all_delivered", 32'(exp_q.size()), 32'd0);

    // Inter-byte timeout after a partial packet.
    send_byte(8'hA5);
    send_byte(8'h32);
    idle(11990);
    check("timeout_not_yet", 32'(timeout_count), exp_to);
    idle(20);
    exp_to = 1;
    check("timeout_count", 32'(timeout_count), exp_to);
    send_pkt(9'd100, 9'd200, 1'b1, 16'h1234, 1'b0);
    idle(3);
    check("after_timeout_queue", 32'(exp_q.size()), 32'd0);

    // Reset while an event is held and a packet is half received.
    event_ready = 1'b0;
    send_pkt(9'd1, 9'd2, 1'b0, 16'h4444, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h32);
    send_byte(8'h32);
    send_byte(8'h20);
    rst = 1'b1;
    idle(1);
    exp_q.delete();
    exp_chk = 0; exp_rng = 0; exp_to = 0;
    check("midrst_event_valid", 32'(event_valid),   32'd0);
    check("midrst_event_x",     32'(event_x),       32'd0);
    check("midrst_chk_cnt",     32'(chk_err_count), exp_chk);
    check("midrst_to_cnt",      32'(timeout_count), exp_to);
    rst = 1'b0;
    event_ready = 1'b1;
    idle(1);
    send_pkt(9'd77, 9'd88, 1'b1, 16'h5678, 1'b0);
    check("post_rst_latency", 32'(event_valid), 32'd1);
    idle(3);
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    // Checksum error counter saturates rather than wrapping.
    for (int k = 0; k < 257; k++) send_pkt(9'd3, 9'd4, 1'b0, 16'h0000, 1'b1);
    idle(3);
    check("chk_saturate", 32'(chk_err_count), exp_chk);
    check("chk_saturate_255", 32'(chk_err_count), 32'd255);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvs_event_decoder.md
DVS_EVENT_DECODER -- requirements
Module: dvs_event_decoder

Interface
REQ-001 SHALL have parameter SENSOR_RES, default 320: valid coordinate range 0..SENSOR_RES-1.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 12_000: inter-byte timeout in clk cycles (1 ms at 12 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  byte available from UART RX.
REQ-006 SHALL have port in_data  input  8  received byte.
REQ-007 SHALL have port in_ready  output  1  decoder accepts byte; transfer when in_valid && in_ready.
REQ-008 SHALL have port event_valid  output  1  decoded event held.
REQ-009 SHALL have port event_x  output  9  event X coordinate.
REQ-010 SHALL have port event_y  output  9  event Y coordinate.
REQ-011 SHALL have port event_polarity  output  1  1=ON, 0=OFF.
REQ-012 SHALL have port event_ts  output  16  event timestamp.
REQ-013 SHALL have port event_ready  input  1  consumer accepts; transfer when event_valid && event_ready.
REQ-014 SHALL have port chk_err_count  output  8  saturating count of checksum failures.
REQ-015 SHALL have port range_drop_count  output  8  saturating count of out-of-range drops.
REQ-016 SHALL have port timeout_count  output  8  saturating count of inter-byte timeouts.

Function
REQ-017 SHALL decode 7-byte packets: B0=0xA5 sync; B1=x[8:1]; B2={x[0],y[8:2]}; B3={y[1:0],pol,5'b0}; B4=ts[15:8]; B5=ts[7:0]; B6=B1^B2^B3^B4^B5.
REQ-018 SHALL implement FSM states HUNT, COLLECT, STALL; reset state HUNT.
REQ-019 HUNT: discard every byte except 0xA5; on 0xA5 clear byte index to 1, clear running XOR, go COLLECT.
REQ-020 COLLECT: store B1..B5 by index, XOR into running checksum; 0xA5 inside payload is data, not resync.
REQ-021 On B6: mismatch -> increment chk_err_count, go HUNT, no event; match with x>=SENSOR_RES or y>=SENSOR_RES -> increment range_drop_count, go HUNT; otherwise load output register, go HUNT.
REQ-022 Valid B6 arriving while output register full and not draining the same cycle -> go STALL holding decoded fields; STALL loads output register on the cycle it frees, then HUNT.
REQ-023 in_ready SHALL be 1 in HUNT and COLLECT, 0 in STALL.
REQ-024 event_valid SHALL rise the cycle after the accepted B6 byte when output register empty (latency 1).
REQ-025 Output register SHALL hold all event_* fields stable while event_valid && !event_ready.
REQ-026 Load and drain in same cycle SHALL be allowed (full throughput, no bubble).
REQ-027 Timeout counter SHALL reset on every accepted byte, run only in COLLECT; on reaching TIMEOUT_CYCLES-1 -> increment timeout_count, go HUNT, discard partial packet.
REQ-028 All three counters SHALL saturate at 255, never wrap.

Reset
REQ-029 On rst: state HUNT, byte index 0, XOR 0, timeout counter 0, event_valid 0, event_x/event_y/event_ts 0, event_polarity 0, all error counters 0.
REQ-030 rst mid-packet or mid-STALL SHALL discard partial/pending event; first packet after reset decodes normally.

Structure
REQ-031 Shared package dvs_pkg SHALL hold SYNC_BYTE (0xA5), PKT_LEN (7), COORD_W (9), TS_W (16) and the decoder state enum.
REQ-032 Block SHALL be a single module with no sub-modules; timeout and counters inline.

Verification
REQ-033 Packet A5 32 32 20 12 34 06, event_ready=1 -> one event x=100 y=200 pol=1 ts=0x1234, event_valid 1 cycle after 0x06.
REQ-034 Same packet with last byte 0x07 -> no event, chk_err_count=1, next valid packet decodes.
REQ-035 Bytes 00 FF then packet for x=320 (B1=0xA0,B2=0x00) -> garbage ignored, no event, range_drop_count=1.
REQ-036 Three back-to-back valid packets with event_ready=0 -> first held stable, second causes STALL with in_ready=0; raise event_ready -> all three delivered in order, none lost.
REQ-037 A5 32 then 12_000 idle cycles -> timeout_count=1, state HUNT; following full packet decodes.
REQ-038 rst asserted after B3 of a packet -> outputs cleared, partial discarded, subsequent packet decodes correctly.
